// File: rtl/table_streamer.sv
// rtl/table_streamer.sv - streams an init-patterned NRxNC table in row- or column-major order with a running sum
module table_streamer #(
   parameter int NX        = 8,
   parameter int NR        = 4,
   parameter int NC        = 4,
   parameter int INIT_BASE = 0,
   parameter int INIT_STEP = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_mode,
   input  logic          i_wr_en,
   input  logic [1:0]    i_wr_row,
   input  logic [1:0]    i_wr_col,
   input  logic [NX-1:0] i_wr_data,
   output logic [NX-1:0] o_data,
   output logic [1:0]    o_row,
   output logic [1:0]    o_col,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_last,
   output logic [NX+3:0] o_sum,
   output logic          o_busy,
   output logic          o_done
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;
   localparam logic [1:0] ROW_MAX  = 2'(NR - 1);
   localparam logic [1:0] COL_MAX  = 2'(NC - 1);

   logic [NX-1:0] r_table [NR][NC];
   logic [0:0]    r_state;
   logic          r_mode;
   logic [1:0]    r_row;
   logic [1:0]    r_col;
   logic [NX+3:0] r_sum;
   logic          r_done;

   logic          w_valid;
   logic          w_hs;
   logic          w_last;
   logic [NX-1:0] w_data;

   function automatic logic [NX-1:0] init_val(input int r, input int c);
      logic [31:0] v;
      v = 32'(INIT_BASE + INIT_STEP * (r * NC + c));
      return v[NX-1:0];
   endfunction

   assign w_valid = (r_state == S_STREAM);
   assign w_hs    = w_valid & i_ready;
   assign w_last  = w_valid & (r_row == ROW_MAX) & (r_col == COL_MAX);
   assign w_data  = r_table[r_row][r_col];

   // Reset reloads the whole table, so a mid-stream reset also discards any patches.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
               r_table[r][c] <= init_val(r, c);
            end
         end
      end else if ((r_state == S_IDLE) && i_wr_en) begin
         r_table[i_wr_row][i_wr_col] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_row   <= 2'd0;
         r_col   <= 2'd0;
         r_sum   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mode  <= i_mode;
                  r_row   <= 2'd0;
                  r_col   <= 2'd0;
                  r_sum   <= '0;
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_hs) begin
                  r_sum <= r_sum + {4'b0000, w_data};
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_row   <= 2'd0;
                     r_col   <= 2'd0;
                     r_done  <= 1'b1;
                  end else if (!r_mode) begin
                     if (r_col == COL_MAX) begin
                        r_col <= 2'd0;
                        r_row <= r_row + 2'd1;
                     end else begin
                        r_col <= r_col + 2'd1;
                     end
                  end else begin
                     if (r_row == ROW_MAX) begin
                        r_row <= 2'd0;
                        r_col <= r_col + 2'd1;
                     end else begin
                        r_row <= r_row + 2'd1;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_data  = w_data;
   assign o_row   = r_row;
   assign o_col   = r_col;
   assign o_valid = w_valid;
   assign o_last  = w_last;
   assign o_sum   = r_sum;
   assign o_busy  = w_valid;
   assign o_done  = r_done;

endmodule

// File: tb/tb_table_streamer.sv
// tb/tb_table_streamer.sv - directed vector bench for table_streamer
module tb_table_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, mode, wr_en, ready;
   logic [1:0]  wr_row, wr_col;
   logic [7:0]  wr_data;
   logic [7:0]  o_data;
   logic [1:0]  o_row, o_col;
   logic        o_valid, o_last, o_busy, o_done;
   logic [11:0] o_sum;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_tab [4][4];
   logic       pend_wr;
   logic [1:0] pend_r, pend_c;
   logic [7:0] pend_d;

   always #5 clk = ~clk;

   table_streamer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
      .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
      .o_data(o_data), .o_row(o_row), .o_col(o_col), .o_valid(o_valid),
      .i_ready(ready), .o_last(o_last), .o_sum(o_sum), .o_busy(o_busy), .o_done(o_done)
   );

   typedef struct {
      logic       rst;
      logic       wr;
      logic       same;
      logic [1:0] wr_r;
      logic [1:0] wr_c;
      logic [7:0] wd;
      logic       md;
      int         exp_sum;
      int         exp_b6;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m_tab[r][c] = 8'(r * 4 + c);
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_busy",  32'(o_busy),  0);
      chk("rst_done",  32'(o_done),  0);
      chk("rst_last",  32'(o_last),  0);
      chk("rst_sum",   32'(o_sum),   0);
      chk("rst_row",   32'(o_row),   0);
      chk("rst_col",   32'(o_col),   0);
      chk("rst_data",  32'(o_data),  32'(m_tab[0][0]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_write(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      m_tab[r][c] = d;
   endtask

   // Streams one full table; bp selects ready pattern 1,0,0,...; disturb_at injects START+WR_EN mid-stream.
   task automatic run_stream(input logic md, input logic bp, input int disturb_at,
                             output int sum_out, output int b6);
      int beats = 0;
      int cyc = 0;
      int msum = 0;
      int r, c;
      @(negedge clk);
      start = 1'b1; mode = md; ready = 1'b1;
      if (pend_wr) begin
         wr_en = 1'b1; wr_row = pend_r; wr_col = pend_c; wr_data = pend_d;
         m_tab[pend_r][pend_c] = pend_d;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; pend_wr = 1'b0;
      mode = ~md;
      b6 = -1;
      while (beats < 16 && cyc < 100) begin
         r = md ? beats % 4 : beats / 4;
         c = md ? beats / 4 : beats % 4;
         chk("valid", 32'(o_valid), 1);
         chk("busy",  32'(o_busy),  1);
         chk("done_mid", 32'(o_done), 0);
         chk("data",  32'(o_data),  32'(m_tab[r][c]));
         chk("row",   32'(o_row),   32'(r));
         chk("col",   32'(o_col),   32'(c));
         chk("last",  32'(o_last),  32'(beats == 15));
         chk("sum_run", 32'(o_sum), 32'(msum));
         if (beats == 6) b6 = int'(o_data);
         ready = bp ? (cyc % 3 == 0) : 1'b1;
         if (beats == disturb_at && cyc >= 0 && !start && wr_en == 1'b0 && disturb_at >= 0) begin
            start = 1'b1; wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
            disturb_at = -1;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (ready) begin
            msum += int'(m_tab[r][c]);
            beats++;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0; ready = 1'b1;
      chk("beat_count", 32'(beats), 16);
      chk("done_pulse", 32'(o_done), 1);
      chk("busy_end",   32'(o_busy), 0);
      chk("valid_end",  32'(o_valid), 0);
      chk("sum_final",  32'(o_sum), 32'(msum));
      sum_out = int'(o_sum);
      @(negedge clk);
      chk("done_clear", 32'(o_done), 0);
      chk("sum_hold",   32'(o_sum), 32'(msum));
   endtask

   vec_t vecs [6];
   int   s, b6;

   initial begin
      vecs[0] = '{rst:0, wr:0, same:0, wr_r:0, wr_c:0, wd:0,   md:0, exp_sum:120, exp_b6:6};
      vecs[1] = '{rst:0, wr:0, same:0, wr_r:0, wr_c:0, wd:0,   md:1, exp_sum:120, exp_b6:9};
      vecs[2] = '{rst:0, wr:1, same:0, wr_r:1, wr_c:2, wd:200, md:0, exp_sum:314, exp_b6:200};
      vecs[3] = '{rst:0, wr:0, same:0, wr_r:0, wr_c:0, wd:0,   md:1, exp_sum:314, exp_b6:9};
      vecs[4] = '{rst:1, wr:0, same:0, wr_r:0, wr_c:0, wd:0,   md:0, exp_sum:120, exp_b6:6};
      vecs[5] = '{rst:0, wr:1, same:1, wr_r:3, wr_c:3, wd:255, md:0, exp_sum:360, exp_b6:6};

      start = 0; mode = 0; wr_en = 0; ready = 1; wr_row = 0; wr_col = 0; wr_data = 0;
      pend_wr = 0; pend_r = 0; pend_c = 0; pend_d = 0;
      model_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].rst) do_reset();
         if (vecs[i].wr && !vecs[i].same) do_write(vecs[i].wr_r, vecs[i].wr_c, vecs[i].wd);
         if (vecs[i].wr && vecs[i].same) begin
            pend_wr = 1'b1; pend_r = vecs[i].wr_r; pend_c = vecs[i].wr_c; pend_d = vecs[i].wd;
         end
         run_stream(vecs[i].md, 1'b0, -1, s, b6);
         chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
         chk($sformatf("vec%0d_beat7", i), 32'(b6), 32'(vecs[i].exp_b6));
      end

      do_reset();
      run_stream(1'b0, 1'b1, -1, s, b6);
      chk("bp_sum", 32'(s), 120);

      run_stream(1'b0, 1'b0, 5, s, b6);
      chk("disturb_sum", 32'(s), 120);
      run_stream(1'b1, 1'b0, -1, s, b6);
      chk("after_disturb_sum", 32'(s), 120);

      @(negedge clk);
      start = 1'b1; mode = 1'b0; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort_beat9", 32'(o_data), 8);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         chk("abort_no_done", 32'(o_done), 0);
         @(negedge clk);
      end
      run_stream(1'b0, 1'b0, -1, s, b6);
      chk("abort_restream_sum", 32'(s), 120);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
